writeback_store: RTL and testbench

//  Final pipeline stage, directly downstream of the memory stage. Retires one instruction per cycle:

---
 rtl/writeback_store.sv | 220 ++++++++++++++++++++++
 tb/tb_writeback_store.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_store.sv
// Writeback stage: retires register results in a single cycle. Stores are issued to the D-cache
// and retire on completion, bounded by a timeout that raises a sticky error flag.
module writeback_store #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] rip_in,
    input  logic [REG_W-1:0]  dest_reg_in,
    input  logic              dest_reg_valid_in,
    input  logic [DATA_W-1:0] dest_value_in,
    input  logic              is_mem_dest_in,
    input  logic [ADDR_W-1:0] mem_addr_dest_in,
    output logic              wb_stall_out,
    output logic              rf_we_out,
    output logic [REG_W-1:0]  rf_waddr_out,
    output logic [DATA_W-1:0] rf_wdata_out,
    output logic              req_cyc_out,
    output logic [ADDR_W-1:0] req_addr_out,
    output logic [DATA_W-1:0] req_data_out,
    input  logic              req_ack_in,
    input  logic              resp_cyc_in,
    output logic              resp_ack_out,
    output logic              retire_valid_out,
    output logic [ADDR_W-1:0] retire_rip_out,
    output logic [31:0]       retired_count_out,
    output logic              store_err_out
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rip_q, rip_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic              dest_valid_q, dest_valid_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              req_cyc_q, req_cyc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic              resp_ack_q, resp_ack_d;
    logic              retire_valid_q, retire_valid_d;
    logic [ADDR_W-1:0] retire_rip_q, retire_rip_d;
    logic [31:0]       count_q, count_d;
    logic              err_q, err_d;
    logic              store_done_s;

    // Next-state and registered-output computation.
    always_comb begin
        state_d        = state_q;
        rip_d          = rip_q;
        dest_d         = dest_q;
        dest_valid_d   = dest_valid_q;
        timer_d        = timer_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        req_cyc_d      = req_cyc_q;
        req_addr_d     = req_addr_q;
        req_data_d     = req_data_q;
        resp_ack_d     = 1'b0;
        retire_valid_d = 1'b0;
        retire_rip_d   = retire_rip_q;
        count_d        = count_q;
        err_d          = err_q;
        store_done_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in == 1'b1) begin
                    if (is_mem_dest_in == 1'b1) begin
                        state_d      = REQ;
                        rip_d        = rip_in;
                        dest_d       = dest_reg_in;
                        dest_valid_d = dest_reg_valid_in;
                        timer_d      = '0;
                        req_cyc_d    = 1'b1;
                        req_addr_d   = mem_addr_dest_in;
                        req_data_d   = dest_value_in;
                    end else begin
                        retire_valid_d = 1'b1;
                        retire_rip_d   = rip_in;
                        rf_we_d        = dest_reg_valid_in;
                        if (dest_reg_valid_in == 1'b1) begin
                            rf_waddr_d = dest_reg_in;
                            rf_wdata_d = dest_value_in;
                        end else begin
                            rf_waddr_d = rf_waddr_q;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (req_ack_in == 1'b1) begin
                    req_cyc_d = 1'b0;
                    if (resp_cyc_in == 1'b1) begin
                        store_done_s = 1'b1;
                    end else begin
                        state_d = RESP;
                        timer_d = timer_q + 1'b1;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    req_cyc_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_cyc_in == 1'b1) begin
                    store_done_s = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A completed store retires in the DONE cycle alongside its resp_ack pulse.
        if (store_done_s == 1'b1) begin
            state_d        = DONE;
            resp_ack_d     = 1'b1;
            retire_valid_d = 1'b1;
            retire_rip_d   = rip_q;
            rf_we_d        = dest_valid_q;
            if (dest_valid_q == 1'b1) begin
                rf_waddr_d = dest_q;
                rf_wdata_d = req_data_q;
            end else begin
                rf_waddr_d = rf_waddr_q;
            end
        end else begin
            store_done_s = 1'b0;
        end

        if (retire_valid_d == 1'b1) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            rip_q          <= '0;
            dest_q         <= '0;
            dest_valid_q   <= 1'b0;
            timer_q        <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            req_cyc_q      <= 1'b0;
            req_addr_q     <= '0;
            req_data_q     <= '0;
            resp_ack_q     <= 1'b0;
            retire_valid_q <= 1'b0;
            retire_rip_q   <= '0;
            count_q        <= 32'd0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            rip_q          <= rip_d;
            dest_q         <= dest_d;
            dest_valid_q   <= dest_valid_d;
            timer_q        <= timer_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            req_cyc_q      <= req_cyc_d;
            req_addr_q     <= req_addr_d;
            req_data_q     <= req_data_d;
            resp_ack_q     <= resp_ack_d;
            retire_valid_q <= retire_valid_d;
            retire_rip_q   <= retire_rip_d;
            count_q        <= count_d;
            err_q          <= err_d;
        end
    end

    assign wb_stall_out      = (state_q != IDLE);
    assign rf_we_out         = rf_we_q;
    assign rf_waddr_out      = rf_waddr_q;
    assign rf_wdata_out      = rf_wdata_q;
    assign req_cyc_out       = req_cyc_q;
    assign req_addr_out      = req_addr_q;
    assign req_data_out      = req_data_q;
    assign resp_ack_out      = resp_ack_q;
    assign retire_valid_out  = retire_valid_q;
    assign retire_rip_out    = retire_rip_q;
    assign retired_count_out = count_q;
    assign store_err_out     = err_q;

endmodule

// File: tb/tb_writeback_store.sv
// Directed bench for writeback_store: register retires, store handshakes, timeout, async reset,
// and retire-counter wrap.
module tb_writeback_store;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [63:0] rip_in;
    logic [3:0]  dest_reg_in;
    logic        dest_reg_valid_in;
    logic [63:0] dest_value_in;
    logic        is_mem_dest_in;
    logic [63:0] mem_addr_dest_in;
    logic        wb_stall_out;
    logic        rf_we_out;
    logic [3:0]  rf_waddr_out;
    logic [63:0] rf_wdata_out;
    logic        req_cyc_out;
    logic [63:0] req_addr_out;
    logic [63:0] req_data_out;
    logic        req_ack_in;
    logic        resp_cyc_in;
    logic        resp_ack_out;
    logic        retire_valid_out;
    logic [63:0] retire_rip_out;
    logic [31:0] retired_count_out;
    logic        store_err_out;

    int checks = 0;
    int errors = 0;

    writeback_store #(.ADDR_W(64), .DATA_W(64), .REG_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .rip_in(rip_in),
        .dest_reg_in(dest_reg_in), .dest_reg_valid_in(dest_reg_valid_in),
        .dest_value_in(dest_value_in), .is_mem_dest_in(is_mem_dest_in),
        .mem_addr_dest_in(mem_addr_dest_in), .wb_stall_out(wb_stall_out),
        .rf_we_out(rf_we_out), .rf_waddr_out(rf_waddr_out), .rf_wdata_out(rf_wdata_out),
        .req_cyc_out(req_cyc_out), .req_addr_out(req_addr_out), .req_data_out(req_data_out),
        .req_ack_in(req_ack_in), .resp_cyc_in(resp_cyc_in), .resp_ack_out(resp_ack_out),
        .retire_valid_out(retire_valid_out), .retire_rip_out(retire_rip_out),
        .retired_count_out(retired_count_out), .store_err_out(store_err_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic is_mem, input logic [3:0] rd, input logic rd_v,
                           input logic [63:0] val, input logic [63:0] addr, input logic [63:0] rip);
        valid_in = 1'b1; is_mem_dest_in = is_mem; dest_reg_in = rd; dest_reg_valid_in = rd_v;
        dest_value_in = val; mem_addr_dest_in = addr; rip_in = rip;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; is_mem_dest_in = 1'b0; dest_reg_in = 4'd0;
        dest_reg_valid_in = 1'b0; dest_value_in = 64'd0; mem_addr_dest_in = 64'd0;
        rip_in = 64'd0; req_ack_in = 1'b0; resp_cyc_in = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({wb_stall_out, rf_we_out, req_cyc_out, resp_ack_out, retire_valid_out, store_err_out} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes got %b want 000000",
                {wb_stall_out, rf_we_out, req_cyc_out, resp_ack_out, retire_valid_out, store_err_out});
        end
        checks++;
        if (retired_count_out !== 32'd0 || rf_waddr_out !== 4'd0 || rf_wdata_out !== 64'd0 ||
            req_addr_out !== 64'd0 || req_data_out !== 64'd0 || retire_rip_out !== 64'd0) begin
            errors++; $display("FAIL reset_values count=%h waddr=%h wdata=%h want all 0",
                retired_count_out, rf_waddr_out, rf_wdata_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] val;
        for (int i = 1; i <= 3; i++) begin
            val = 64'h11 * i;
            present(1'b0, 4'(i), 1'b1, val, 64'd0, 64'h400 + 64'(i));
            tick();
            checks++;
            if (rf_we_out !== 1'b1 || rf_waddr_out !== 4'(i) || rf_wdata_out !== val) begin
                errors++; $display("FAIL b2b_rf[%0d] we=%b waddr=%h wdata=%h want 1 %h %h",
                    i, rf_we_out, rf_waddr_out, rf_wdata_out, 4'(i), val);
            end
            checks++;
            if (retire_valid_out !== 1'b1 || retire_rip_out !== 64'h400 + 64'(i) || wb_stall_out !== 1'b0) begin
                errors++; $display("FAIL b2b_retire[%0d] ret=%b rip=%h stall=%b want 1 %h 0",
                    i, retire_valid_out, retire_rip_out, wb_stall_out, 64'h400 + 64'(i));
            end
        end
        valid_in = 1'b0;
        tick();
        checks++;
        if (rf_we_out !== 1'b0 || retire_valid_out !== 1'b0 || retired_count_out !== 32'd3 ||
            rf_waddr_out !== 4'd3 || rf_wdata_out !== 64'h33) begin
            errors++; $display("FAIL b2b_after we=%b ret=%b count=%0d waddr=%h wdata=%h want 0 0 3 3 33",
                rf_we_out, retire_valid_out, retired_count_out, rf_waddr_out, rf_wdata_out);
        end
    endtask

    task automatic test_store();
        int req_cycles = 0;
        int retires = 0;
        int rf_writes = 0;
        int acks = 0;
        present(1'b1, 4'd7, 1'b0, 64'hDEAD, 64'h1000, 64'h500);
        tick();
        valid_in = 1'b0;
        checks++;
        if (req_cyc_out !== 1'b1 || req_addr_out !== 64'h1000 || req_data_out !== 64'hDEAD || wb_stall_out !== 1'b1) begin
            errors++; $display("FAIL store_req cyc=%b addr=%h data=%h stall=%b want 1 1000 dead 1",
                req_cyc_out, req_addr_out, req_data_out, wb_stall_out);
        end
        for (int c = 0; c < 8; c++) begin
            req_cycles += int'(req_cyc_out);
            retires    += int'(retire_valid_out);
            rf_writes  += int'(rf_we_out);
            acks       += int'(resp_ack_out);
            req_ack_in  = (c == 2);
            resp_cyc_in = (c == 5);
            if (c == 6) begin
                checks++;
                if (resp_ack_out !== 1'b1 || retire_valid_out !== 1'b1 || retire_rip_out !== 64'h500 ||
                    retired_count_out !== 32'd4) begin
                    errors++; $display("FAIL store_done ack=%b ret=%b rip=%h count=%0d want 1 1 500 4",
                        resp_ack_out, retire_valid_out, retire_rip_out, retired_count_out);
                end
            end
            tick();
        end
        req_ack_in = 1'b0; resp_cyc_in = 1'b0;
        checks++;
        if (req_cycles !== 3 || retires !== 1 || rf_writes !== 0 || acks !== 1 || wb_stall_out !== 1'b0) begin
            errors++; $display("FAIL store_counts req=%0d ret=%0d rf=%0d ack=%0d stall=%b want 3 1 0 1 0",
                req_cycles, retires, rf_writes, acks, wb_stall_out);
        end
    endtask

    task automatic test_fast_store();
        present(1'b1, 4'd9, 1'b0, 64'h77, 64'h2000, 64'h600);
        tick();
        valid_in = 1'b0;
        req_ack_in = 1'b1; resp_cyc_in = 1'b1;
        tick();
        req_ack_in = 1'b0; resp_cyc_in = 1'b0;
        checks++;
        if (resp_ack_out !== 1'b1 || retire_valid_out !== 1'b1 || retire_rip_out !== 64'h600 ||
            req_cyc_out !== 1'b0 || retired_count_out !== 32'd5) begin
            errors++; $display("FAIL fast_done ack=%b ret=%b rip=%h cyc=%b count=%0d want 1 1 600 0 5",
                resp_ack_out, retire_valid_out, retire_rip_out, req_cyc_out, retired_count_out);
        end
        tick();
        checks++;
        if (wb_stall_out !== 1'b0 || resp_ack_out !== 1'b0 || retire_valid_out !== 1'b0) begin
            errors++; $display("FAIL fast_idle stall=%b ack=%b ret=%b want 0 0 0",
                wb_stall_out, resp_ack_out, retire_valid_out);
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int retires = 0;
        int waited = 0;
        present(1'b1, 4'd2, 1'b1, 64'h99, 64'h3000, 64'h700);
        tick();
        valid_in = 1'b0;
        while (wb_stall_out === 1'b1 && waited < 20) begin
            req_cycles += int'(req_cyc_out);
            retires    += int'(retire_valid_out | rf_we_out);
            waited++;
            tick();
        end
        checks++;
        if (waited >= 20) begin
            errors++; $display("FAIL timeout_bound stall still high after %0d cycles want release", waited);
        end
        checks++;
        if (req_cycles !== 8 || retires !== 0 || store_err_out !== 1'b1 || req_cyc_out !== 1'b0 ||
            retired_count_out !== 32'd5) begin
            errors++; $display("FAIL timeout req=%0d ret=%0d err=%b cyc=%b count=%0d want 8 0 1 0 5",
                req_cycles, retires, store_err_out, req_cyc_out, retired_count_out);
        end
        resp_cyc_in = 1'b1;
        tick();
        resp_cyc_in = 1'b0;
        checks++;
        if (resp_ack_out !== 1'b0 || retire_valid_out !== 1'b0 || store_err_out !== 1'b1) begin
            errors++; $display("FAIL late_resp ack=%b ret=%b err=%b want 0 0 1",
                resp_ack_out, retire_valid_out, store_err_out);
        end
    endtask

    task automatic test_async_reset();
        present(1'b1, 4'd4, 1'b0, 64'h55, 64'h4000, 64'h800);
        tick();
        valid_in = 1'b0;
        req_ack_in = 1'b1;
        tick();
        req_ack_in = 1'b0;
        checks++;
        if (wb_stall_out !== 1'b1 || req_cyc_out !== 1'b0) begin
            errors++; $display("FAIL resp_wait stall=%b cyc=%b want 1 0", wb_stall_out, req_cyc_out);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({wb_stall_out, req_cyc_out, store_err_out, retire_valid_out} !== 4'b0 ||
            retired_count_out !== 32'd0 || req_addr_out !== 64'd0 || req_data_out !== 64'd0 ||
            retire_rip_out !== 64'd0 || rf_wdata_out !== 64'd0) begin
            errors++; $display("FAIL async_reset stall=%b cyc=%b err=%b count=%0d addr=%h want all 0",
                wb_stall_out, req_cyc_out, store_err_out, retired_count_out, req_addr_out);
        end
        #2 reset = 1'b0;
        present(1'b1, 4'd5, 1'b1, 64'hBEEF, 64'h5000, 64'h900);
        tick();
        valid_in = 1'b0;
        checks++;
        if (req_cyc_out !== 1'b1 || req_addr_out !== 64'h5000 || req_data_out !== 64'hBEEF) begin
            errors++; $display("FAIL post_reset_req cyc=%b addr=%h data=%h want 1 5000 beef",
                req_cyc_out, req_addr_out, req_data_out);
        end
        req_ack_in = 1'b1; resp_cyc_in = 1'b1;
        tick();
        req_ack_in = 1'b0; resp_cyc_in = 1'b0;
        checks++;
        if (retire_valid_out !== 1'b1 || rf_we_out !== 1'b1 || rf_waddr_out !== 4'd5 ||
            rf_wdata_out !== 64'hBEEF || retired_count_out !== 32'd1 || store_err_out !== 1'b0) begin
            errors++; $display("FAIL post_reset_done ret=%b we=%b waddr=%h wdata=%h count=%0d err=%b want 1 1 5 beef 1 0",
                retire_valid_out, rf_we_out, rf_waddr_out, rf_wdata_out, retired_count_out, store_err_out);
        end
        tick();
    endtask

    task automatic test_count_wrap();
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        present(1'b0, 4'd6, 1'b0, 64'h66, 64'd0, 64'hA00);
        tick();
        valid_in = 1'b0;
        checks++;
        if (retired_count_out !== 32'd0 || retire_valid_out !== 1'b1 || rf_we_out !== 1'b0 ||
            rf_waddr_out !== 4'd5) begin
            errors++; $display("FAIL count_wrap count=%h ret=%b we=%b waddr=%h want 0 1 0 5",
                retired_count_out, retire_valid_out, rf_we_out, rf_waddr_out);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_store();
        test_fast_store();
        test_timeout();
        test_async_reset();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
